// File: rtl/cvxif_issue_master.sv
// Core-side CV-X-IF issue/result initiator.
// Takes one offloaded instruction at a time, drives the issue request until the
// handshake, samples the accept/writeback response and, when a result is promised,
// waits (with optional timeout) for the matching result and writes it back.
module cvxif_issue_master #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ID_W    = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic            clk_i,
    input  logic            rst_i,
    // core pipeline side
    input  logic            instr_valid_i,
    output logic            instr_ready_o,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    // issue channel
    output logic            issue_valid_o,
    input  logic            issue_ready_i,
    output logic [31:0]     issue_instr_o,
    output logic [XLEN-1:0] issue_rs0_o,
    output logic [XLEN-1:0] issue_rs1_o,
    output logic [ID_W-1:0] issue_id_o,
    input  logic            issue_accept_i,
    input  logic            issue_writeback_i,
    // result channel
    input  logic            result_valid_i,
    output logic            result_ready_o,
    input  logic [ID_W-1:0] result_id_i,
    input  logic [XLEN-1:0] result_data_i,
    // register-file write-back and status
    output logic            wb_valid_o,
    output logic [4:0]      wb_rd_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic            done_o,
    output logic            illegal_o,
    output logic            id_err_o,
    output logic            timeout_o,
    output logic            busy_o
);

    // Counter only needs to reach TIMEOUT-1.
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TMAX = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StIssue   = 2'd1,
        StWaitRes = 2'd2
    } state_e;

    state_e          state;
    logic [ID_W-1:0] id_cnt;
    logic [CW-1:0]   tcnt;
    logic            res_match;

    // Handshake-level outputs decode directly from the registered state.
    assign instr_ready_o  = (state == StIdle);
    assign issue_valid_o  = (state == StIssue);
    assign result_ready_o = (state == StWaitRes);
    assign busy_o         = (state != StIdle);
    assign res_match      = result_valid_i && (result_id_i == issue_id_o);

    // Transaction FSM with registered payload and one-cycle status pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= StIdle;
            id_cnt        <= '0;
            tcnt          <= '0;
            issue_instr_o <= '0;
            issue_rs0_o   <= '0;
            issue_rs1_o   <= '0;
            issue_id_o    <= '0;
            wb_valid_o    <= 1'b0;
            wb_rd_o       <= '0;
            wb_data_o     <= '0;
            done_o        <= 1'b0;
            illegal_o     <= 1'b0;
            id_err_o      <= 1'b0;
            timeout_o     <= 1'b0;
        end else begin
            wb_valid_o <= 1'b0;
            done_o     <= 1'b0;
            illegal_o  <= 1'b0;
            id_err_o   <= 1'b0;
            timeout_o  <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (instr_valid_i) begin
                        issue_instr_o <= instr_i;
                        issue_rs0_o   <= rs1_i;
                        issue_rs1_o   <= rs2_i;
                        issue_id_o    <= id_cnt;
                        id_cnt        <= id_cnt + 1'b1;
                        state         <= StIssue;
                    end
                end
                StIssue: begin
                    // Response is only meaningful in the handshake cycle.
                    if (issue_ready_i) begin
                        if (!issue_accept_i) begin
                            illegal_o <= 1'b1;
                            state     <= StIdle;
                        end else if (!issue_writeback_i) begin
                            done_o <= 1'b1;
                            state  <= StIdle;
                        end else begin
                            tcnt  <= '0;
                            state <= StWaitRes;
                        end
                    end
                end
                StWaitRes: begin
                    tcnt <= tcnt + 1'b1;
                    if (res_match) begin
                        // A matching result wins over a timeout in the same cycle.
                        done_o <= 1'b1;
                        if (issue_instr_o[11:7] != 5'd0) begin
                            wb_valid_o <= 1'b1;
                            wb_rd_o    <= issue_instr_o[11:7];
                            wb_data_o  <= result_data_i;
                        end
                        state <= StIdle;
                    end else begin
                        // A stray id is consumed but does not restart the timeout.
                        if (result_valid_i) begin
                            id_err_o <= 1'b1;
                        end
                        if ((TIMEOUT != 0) && (tcnt == TMAX)) begin
                            timeout_o <= 1'b1;
                            state     <= StIdle;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/cvxif_issue_master.md
Name: cvxif_issue_master

Overview:
- Core-side initiator of the CV-X-IF issue and result channels: the counterpart of the coprocessor decoder that accepts custom-opcode (0001011) instructions.
- Takes one offloaded instruction at a time from the core pipeline and drives the issue request (instr, rs[0], rs[1], id) until the handshake completes.
- Samples the accept/writeback response, then, when writeback was promised, waits for the matching result and writes it back to the register file.
- Single outstanding instruction; timeout protection on the result phase.

Parameters:
XLEN, 32, width of register operands and result data
ID_W, 4, width of the issue/result transaction id
TIMEOUT, 1024, cycles to wait for a result before aborting; 0 disables timeout

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-high reset
instr_valid_i  in  1  core presents an instruction to offload
instr_ready_o  out  1  block can take an instruction
instr_i  in  32  instruction word
rs1_i  in  XLEN  register operand 1 value
rs2_i  in  XLEN  register operand 2 value
issue_valid_o  out  1  issue request valid
issue_ready_i  in  1  coprocessor ready for issue
issue_instr_o  out  32  issued instruction word
issue_rs0_o  out  XLEN  rs[0] = rs1 value
issue_rs1_o  out  XLEN  rs[1] = rs2 value
issue_id_o  out  ID_W  transaction id
issue_accept_i  in  1  response: instruction accepted
issue_writeback_i  in  1  response: result will be written back
result_valid_i  in  1  coprocessor result valid
result_ready_o  out  1  block can take a result
result_id_i  in  ID_W  id of the result
result_data_i  in  XLEN  result value
wb_valid_o  out  1  one-cycle register-file write strobe
wb_rd_o  out  5  destination register (instr[11:7] of the issued instruction)
wb_data_o  out  XLEN  write-back data
done_o  out  1  one-cycle pulse: instruction retired (accepted, result written back if writeback was promised)
illegal_o  out  1  one-cycle pulse: coprocessor rejected the instruction
id_err_o  out  1  one-cycle pulse: result with a non-matching id was consumed
timeout_o  out  1  one-cycle pulse: result phase aborted
busy_o  out  1  state != IDLE

Behaviour:
- Reset (async, rst_i=1): state IDLE; id counter 0; all latched operand registers 0; every output 0 except instr_ready_o, which is 1 in IDLE after reset.
- States: IDLE, ISSUE, WAIT_RES.
- IDLE:
  - instr_ready_o=1.
  - instr_valid_i=1: latch instr_i/rs1_i/rs2_i, assign issue_id_o = current id, increment id (modulo 2^ID_W, wraps), go to ISSUE.
  - Latency: handshake in cycle N, issue_valid_o=1 in N+1.
- ISSUE:
  - issue_valid_o=1; issue_instr_o/rs0/rs1/id held stable until issue_ready_i=1 (no withdrawal).
  - issue_accept_i and issue_writeback_i are sampled only in the issue_valid_o && issue_ready_i cycle.
  - accept=0: illegal_o pulse next cycle, go to IDLE.
  - accept=1, writeback=0: done_o pulse next cycle, go to IDLE.
  - accept=1, writeback=1: go to WAIT_RES; clear timeout counter.
- WAIT_RES:
  - result_ready_o=1; timeout counter increments each cycle.
  - result_valid_i with result_id_i == latched id:
    - wb_valid_o=1 next cycle with wb_rd_o = instr[11:7] and wb_data_o = result_data_i.
    - rd==0: wb_valid_o suppressed; done_o still pulses.
    - Go to IDLE.
  - result_valid_i with mismatching id: result consumed, id_err_o pulse, stay in WAIT_RES; counter not reset.
  - TIMEOUT!=0 and counter reaches TIMEOUT-1 with no matching result: timeout_o pulse, go to IDLE.
  - A matching result in that same cycle wins; no timeout_o.
- Results arriving outside WAIT_RES: result_ready_o=0, not consumed.
- instr_ready_o=0 in ISSUE and WAIT_RES; pulse outputs are registered, exactly one cycle wide.
- Reset asserted mid-transaction: immediate return to IDLE, id to 0, no pulses; any in-flight result is dropped.
- wb_rd_o/wb_data_o hold their last value when wb_valid_o=0.

Test Plan:
- Reject: instr 0x0000_0033, issue_ready_i=1, accept=0 -> issue_valid_o one cycle after instr handshake; illegal_o pulse; back in IDLE; id advanced 0->1.
- Accept without writeback: instr 0x0000_000B (funct3=000), rs1=0x1000, rs2=0x2000, accept=1, writeback=0 -> issue_rs0_o=0x1000, issue_rs1_o=0x2000; done_o pulse; no wb_valid_o.
- Writeback: instr 0x0000_328B (funct3=011, rd=5), accept=1, writeback=1, result id match with data 0xDEADBEEF three cycles later -> wb_valid_o=1, wb_rd_o=5, wb_data_o=0xDEADBEEF, done_o.
- Backpressure and id check: issue_ready_i low 4 cycles -> issue_* stable all 4 cycles. In WAIT_RES, result with wrong id -> id_err_o pulse; a following matching result still written back.
- Timeout and rd=0: TIMEOUT=8, no result -> timeout_o pulse exactly 8 cycles after entering WAIT_RES. Separately, rd=0 writeback -> done_o, no wb_valid_o.
- Wrap and reset: 17 instructions with ID_W=4 -> the 17th uses id 0. Assert rst_i in WAIT_RES -> state IDLE, busy_o=0, all pulse outputs 0.
